// File: rtl/aes_pkg.sv
// Shared constants, FSM state type and GF(2^8) helper for the MixColumns datapath.
package aes_pkg;

    // Bit offsets of the four state columns inside the 128-bit state word.
    localparam int COL_0 = 96;
    localparam int COL_1 = 64;
    localparam int COL_2 = 32;
    localparam int COL_3 = 0;

    // Byte offsets of the four rows inside a 32-bit column.
    localparam int ROW_0 = 24;
    localparam int ROW_1 = 16;
    localparam int ROW_2 = 8;
    localparam int ROW_3 = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multiply by x (i.e. by 2) in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Handshake and data bundle between a producer and mix_columns_seq.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] o_state;
    logic         busy;

    modport slave (
        input  in_valid, state, inv, out_ready,
        output in_ready, out_valid, o_state, busy
    );

    modport master (
        output in_valid, state, inv, out_ready,
        input  in_ready, out_valid, o_state, busy
    );
endinterface

// File: rtl/mix_column_word.sv
// Combinational (Inv)MixColumns on a single 32-bit column.
module mix_column_word #(
    parameter int ROW_0 = aes_pkg::ROW_0,
    parameter int ROW_1 = aes_pkg::ROW_1,
    parameter int ROW_2 = aes_pkg::ROW_2,
    parameter int ROW_3 = aes_pkg::ROW_3
) (
    input  logic [31:0] i_col,
    input  logic        i_inv,
    output logic [31:0] o_col
);
    import aes_pkg::*;

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_x2_0, w_x2_1, w_x2_2, w_x2_3;
    logic [7:0] w_x4_0, w_x4_1, w_x4_2, w_x4_3;
    logic [7:0] w_x8_0, w_x8_1, w_x8_2, w_x8_3;
    logic [7:0] w_r0, w_r1, w_r2, w_r3;

    assign w_a0 = i_col[ROW_0 +: 8];
    assign w_a1 = i_col[ROW_1 +: 8];
    assign w_a2 = i_col[ROW_2 +: 8];
    assign w_a3 = i_col[ROW_3 +: 8];

    // Powers of x for each byte; every coefficient below is an XOR of these.
    assign w_x2_0 = xtime(w_a0);
    assign w_x2_1 = xtime(w_a1);
    assign w_x2_2 = xtime(w_a2);
    assign w_x2_3 = xtime(w_a3);
    assign w_x4_0 = xtime(w_x2_0);
    assign w_x4_1 = xtime(w_x2_1);
    assign w_x4_2 = xtime(w_x2_2);
    assign w_x4_3 = xtime(w_x2_3);
    assign w_x8_0 = xtime(w_x4_0);
    assign w_x8_1 = xtime(w_x4_1);
    assign w_x8_2 = xtime(w_x4_2);
    assign w_x8_3 = xtime(w_x4_3);

    // Row products: forward uses {2,3,1,1}, inverse uses {0e,0b,0d,09}, rotated per row.
    // 09 = x8^a, 0b = x8^x2^a, 0d = x8^x4^a, 0e = x8^x4^x2.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        w_r0 = '0;
        w_r1 = '0;
        w_r2 = '0;
        w_r3 = '0;
        if (i_inv) begin
            w_r0 = (w_x8_0 ^ w_x4_0 ^ w_x2_0) ^ (w_x8_1 ^ w_x2_1 ^ w_a1)
                 ^ (w_x8_2 ^ w_x4_2 ^ w_a2)   ^ (w_x8_3 ^ w_a3);
            w_r1 = (w_x8_0 ^ w_a0)            ^ (w_x8_1 ^ w_x4_1 ^ w_x2_1)
                 ^ (w_x8_2 ^ w_x2_2 ^ w_a2)   ^ (w_x8_3 ^ w_x4_3 ^ w_a3);
            w_r2 = (w_x8_0 ^ w_x4_0 ^ w_a0)   ^ (w_x8_1 ^ w_a1)
                 ^ (w_x8_2 ^ w_x4_2 ^ w_x2_2) ^ (w_x8_3 ^ w_x2_3 ^ w_a3);
            w_r3 = (w_x8_0 ^ w_x2_0 ^ w_a0)   ^ (w_x8_1 ^ w_x4_1 ^ w_a1)
                 ^ (w_x8_2 ^ w_a2)            ^ (w_x8_3 ^ w_x4_3 ^ w_x2_3);
        end else begin
            w_r0 = w_x2_0 ^ (w_x2_1 ^ w_a1) ^ w_a2 ^ w_a3;
            w_r1 = w_a0 ^ w_x2_1 ^ (w_x2_2 ^ w_a2) ^ w_a3;
            w_r2 = w_a0 ^ w_a1 ^ w_x2_2 ^ (w_x2_3 ^ w_a3);
            w_r3 = (w_x2_0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x2_3;
        end
    end

    // Repack the result bytes into the same row layout as the input column.
    always_comb begin
        o_col              = '0;
        o_col[ROW_0 +: 8]  = w_r0;
        o_col[ROW_1 +: 8]  = w_r1;
        o_col[ROW_2 +: 8]  = w_r2;
        o_col[ROW_3 +: 8]  = w_r3;
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential MixColumns / InvMixColumns: one shared column unit, one column per clock.
module mix_columns_seq #(
    parameter int COL_0 = aes_pkg::COL_0,
    parameter int COL_1 = aes_pkg::COL_1,
    parameter int COL_2 = aes_pkg::COL_2,
    parameter int COL_3 = aes_pkg::COL_3,
    parameter int ROW_0 = aes_pkg::ROW_0,
    parameter int ROW_1 = aes_pkg::ROW_1,
    parameter int ROW_2 = aes_pkg::ROW_2,
    parameter int ROW_3 = aes_pkg::ROW_3
) (
    input logic               clk,
    input logic               rst,
    mix_columns_seq_if.slave  bus
);
    import aes_pkg::*;

    state_e       r_state;
    logic [1:0]   r_col_idx;
    logic         r_mode;
    logic [127:0] r_work;
    logic         r_out_valid;
    logic         r_busy;

    logic         w_accept;
    logic [31:0]  w_col_in;
    logic [31:0]  w_col_out;

    // A finished result may be handed off and a new block taken on the same edge.
    assign bus.in_ready = !rst && ((r_state == ST_IDLE) ||
                                   (r_state == ST_DONE && bus.out_ready));
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.o_state   = r_work;

    // Select the column being transformed this RUN cycle.
    always_comb begin
        w_col_in = '0;
        case (r_col_idx)
            2'd0:    w_col_in = r_work[COL_0 +: 32];
            2'd1:    w_col_in = r_work[COL_1 +: 32];
            2'd2:    w_col_in = r_work[COL_2 +: 32];
            default: w_col_in = r_work[COL_3 +: 32];
        endcase
    end

    mix_column_word #(
        .ROW_0 (ROW_0),
        .ROW_1 (ROW_1),
        .ROW_2 (ROW_2),
        .ROW_3 (ROW_3)
    ) u_mix_column_word (
        .i_col (w_col_in),
        .i_inv (r_mode),
        .o_col (w_col_out)
    );

    // Control FSM plus working register; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (rst) begin
            r_state     <= ST_IDLE;
            r_col_idx   <= 2'd0;
            r_mode      <= 1'b0;
            r_work      <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            r_work      <= bus.state;
            r_mode      <= bus.inv;
            r_col_idx   <= 2'd0;
            r_state     <= ST_RUN;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    case (r_col_idx)
                        2'd0:    r_work[COL_0 +: 32] <= w_col_out;
                        2'd1:    r_work[COL_1 +: 32] <= w_col_out;
                        2'd2:    r_work[COL_2 +: 32] <= w_col_out;
                        default: r_work[COL_3 +: 32] <= w_col_out;
                    endcase
                    r_col_idx <= r_col_idx + 2'd1;
                    if (r_col_idx == 2'd3) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed-vector bench for mix_columns_seq.
module tb_mix_columns_seq;

    localparam logic [127:0] V_FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V_FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V_B2B_IN  = {4{32'hd4d4d4d5}};
    localparam logic [127:0] V_B2B_OUT = {4{32'hd5d5d7d6}};
    localparam logic [127:0] V_RST_IN  = {4{32'h2d26314c}};
    localparam logic [127:0] V_RST_OUT = {4{32'h4d7ebdf8}};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mix_columns_seq_if bus ();

    mix_columns_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Present one block from IDLE and wait (bounded) for out_valid.
    // lat counts rising edges after the accept edge.
    task automatic run_block(input logic [127:0] s, input logic m, input logic rdy,
                             input bit scramble, output int lat, output logic [127:0] res);
        @(negedge clk);
        bus.state     = s;
        bus.inv       = m;
        bus.in_valid  = 1'b1;
        bus.out_ready = rdy;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            if (scramble) begin
                bus.inv   = ~bus.inv;
                bus.state = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            lat++;
        end
        res = bus.o_state;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.state     = V_FWD_IN;
        bus.inv       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.o_state !== 128'h0) begin errors++; $display("FAIL reset_o_state got %h want 0", bus.o_state); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_forward();
        int lat;
        logic [127:0] res;
        run_block(V_FWD_IN, 1'b0, 1'b1, 1'b0, lat, res);
        checks++; if (lat !== 4) begin errors++; $display("FAIL fwd_latency got %0d want 4", lat); end
        checks++; if (res !== V_FWD_OUT) begin errors++; $display("FAIL fwd_result got %h want %h", res, V_FWD_OUT); end
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fwd_out_valid_drop got %0b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fwd_idle_busy got %0b want 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fwd_idle_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_inverse();
        int lat;
        logic [127:0] res;
        run_block(V_FWD_OUT, 1'b1, 1'b1, 1'b0, lat, res);
        checks++; if (lat !== 4) begin errors++; $display("FAIL inv_latency got %0d want 4", lat); end
        checks++; if (res !== V_FWD_IN) begin errors++; $display("FAIL inv_result got %h want %h", res, V_FWD_IN); end
    endtask

    task automatic test_backpressure();
        int lat;
        int xfers;
        logic [127:0] res;
        run_block(V_FWD_IN, 1'b0, 1'b0, 1'b0, lat, res);
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d want 4", lat); end
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (bus.o_state !== V_FWD_OUT) begin errors++; $display("FAIL bp_hold_o_state cyc %0d got %h want %h", i, bus.o_state, V_FWD_OUT); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_out_valid cyc %0d got %0b want 1", i, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready cyc %0d got %0b want 0", i, bus.in_ready); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_hold_busy cyc %0d got %0b want 1", i, bus.busy); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        xfers = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.out_valid && bus.out_ready) xfers++;
            @(negedge clk);
        end
        checks++; if (xfers !== 1) begin errors++; $display("FAIL bp_transfer_count got %0d want 1", xfers); end
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int n_res;
        int waited;
        n_res = 0;
        @(negedge clk);
        bus.state     = V_B2B_IN;
        bus.inv       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (bus.out_valid) begin
                n_res++;
                checks++; if (bus.o_state !== V_B2B_OUT) begin errors++; $display("FAIL b2b_result cyc %0d got %h want %h", c, bus.o_state, V_B2B_OUT); end
            end
            if (bus.in_valid && bus.in_ready) acc_cyc.push_back(c);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++; if (acc_cyc.size() !== 4) begin errors++; $display("FAIL b2b_accept_count got %0d want 4", acc_cyc.size()); end
        checks++; if (n_res !== 3) begin errors++; $display("FAIL b2b_result_count got %0d want 3", n_res); end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 5) begin errors++; $display("FAIL b2b_spacing idx %0d got %0d want 5", i, acc_cyc[i] - acc_cyc[i-1]); end
        end
        waited = 0;
        while ((bus.busy || bus.out_valid) && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_drain_busy got %0b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int seen;
        int lat;
        logic [127:0] res;
        @(negedge clk);
        bus.state     = V_FWD_IN;
        bus.inv       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_in_ready_during_rst got %0b want 0", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready_after got %0b want 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", bus.busy); end
        checks++; if (bus.o_state !== 128'h0) begin errors++; $display("FAIL rmid_o_state got %h want 0", bus.o_state); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.out_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_out_valid got %0d want 0", seen); end
        run_block(V_RST_IN, 1'b0, 1'b1, 1'b0, lat, res);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rmid_next_latency got %0d want 4", lat); end
        checks++; if (res !== V_RST_OUT) begin errors++; $display("FAIL rmid_next_result got %h want %h", res, V_RST_OUT); end
    endtask

    task automatic test_mode_change();
        int lat;
        logic [127:0] res;
        @(negedge clk);
        run_block(V_FWD_IN, 1'b0, 1'b1, 1'b1, lat, res);
        checks++; if (lat !== 4) begin errors++; $display("FAIL mode_latency got %0d want 4", lat); end
        checks++; if (res !== V_FWD_OUT) begin errors++; $display("FAIL mode_fwd_result got %h want %h", res, V_FWD_OUT); end
        @(negedge clk);
        run_block(V_FWD_OUT, 1'b1, 1'b1, 1'b1, lat, res);
        checks++; if (res !== V_FWD_IN) begin errors++; $display("FAIL mode_inv_result got %h want %h", res, V_FWD_IN); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_mode_change();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
